// File: rtl/selevy_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : selevy_run_ctrl
//  Purpose  : Run controller for the selevy core. Sequences core reset,
//             enables the core for a bounded cycle budget and snoops the
//             core RAM write port for a store to the tohost word, then
//             reports done / pass / timeout, the run length and exit value.
//  Ports    : CLK, reset          - clock, synchronous active-high reset
//             start               - launch a run (honoured in IDLE/DONE)
//             mem_we/waddr/wdata  - snooped core RAM write port
//             core_reset, core_en - drive the core's reset and clock enable
//             busy                - high while in RESET or RUN
//             done, pass, timeout - sticky run result
//             cycle_count         - RUN cycles elapsed (saturating)
//             exit_code           - data captured from the tohost write
//  Revision : 1.0 - initial release
// ============================================================================
module selevy_run_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 8,
  parameter int CNT_W        = 16,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int TOHOST_ADDR  = 3,
  parameter int PASS_VALUE   = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              core_en,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] exit_code
);

  localparam int RCNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [RCNT_W-1:0] C_RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);
  // Only meaningful when a budget is configured; guarded by C_BUDGETED.
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_SAT   = '1;
  localparam logic [ADDR_W-1:0] C_TOHOST    = ADDR_W'(TOHOST_ADDR);
  localparam logic [DATA_W-1:0] C_PASS      = DATA_W'(PASS_VALUE);
  localparam bit                C_BUDGETED  = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [RCNT_W-1:0]   r_rcnt;

  state_t              w_state;
  logic [RCNT_W-1:0]   w_rcnt;
  logic [CNT_W-1:0]    w_cnt;
  logic [DATA_W-1:0]   w_exit;
  logic                w_done;
  logic                w_pass;
  logic                w_timeout;
  logic                w_hit;
  logic                w_budget_end;

  assign w_hit        = (r_state == S_RUN) && mem_we && (mem_waddr == C_TOHOST);
  assign w_budget_end = C_BUDGETED && (cycle_count == C_CNT_LAST);

  // Next-state and next-output logic. Status registers hold by default.
  always_comb begin
    w_state   = r_state;
    w_rcnt    = r_rcnt;
    w_cnt     = cycle_count;
    w_exit    = exit_code;
    w_done    = done;
    w_pass    = pass;
    w_timeout = timeout;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state   = S_RESET;
          w_rcnt    = '0;
          w_cnt     = '0;
          w_exit    = '0;
          w_done    = 1'b0;
          w_pass    = 1'b0;
          w_timeout = 1'b0;
        end
      end
      S_RESET: begin
        // Exactly RESET_CYCLES edges are spent here before RUN.
        if (r_rcnt == C_RCNT_LAST) begin
          w_state = S_RUN;
        end else begin
          w_rcnt = r_rcnt + 1'b1;
        end
      end
      S_RUN: begin
        // The terminating edge still counts as a run cycle.
        if (cycle_count != C_CNT_SAT) begin
          w_cnt = cycle_count + 1'b1;
        end
        // A tohost store on the last budget cycle wins over the timeout.
        if (w_hit) begin
          w_state = S_DONE;
          w_exit  = mem_wdata;
          w_pass  = (mem_wdata == C_PASS);
          w_done  = 1'b1;
        end else if (w_budget_end) begin
          w_state   = S_DONE;
          w_done    = 1'b1;
          w_timeout = 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and all outputs are registered; core controls follow next state
  // so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rcnt      <= '0;
      core_reset  <= 1'b1;
      core_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      exit_code   <= '0;
    end else begin
      r_state     <= w_state;
      r_rcnt      <= w_rcnt;
      core_reset  <= (w_state != S_RUN);
      core_en     <= (w_state == S_RUN);
      busy        <= (w_state == S_RESET) || (w_state == S_RUN);
      done        <= w_done;
      pass        <= w_pass;
      timeout     <= w_timeout;
      cycle_count <= w_cnt;
      exit_code   <= w_exit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_selevy_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_selevy_run_ctrl
//  Purpose  : Self-checking bench for selevy_run_ctrl. Directed runs push
//             their expected result into a queue; a monitor compares the
//             DUT result whenever done rises. A second instance with an
//             unlimited budget and a narrow counter covers saturation.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_selevy_run_ctrl;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT2_W = 3;

  logic              CLK       = 1'b0;
  logic              reset     = 1'b1;
  logic              start     = 1'b0;
  logic              start2    = 1'b0;
  logic              mem_we    = 1'b0;
  logic [ADDR_W-1:0] mem_waddr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;

  logic              core_reset, core_en, busy, done, pass, timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [DATA_W-1:0] exit_code;

  logic              core_reset2, core_en2, busy2, done2, pass2, timeout2;
  logic [CNT2_W-1:0] cycle_count2;
  logic [DATA_W-1:0] exit_code2;

  selevy_run_ctrl #(
    .RESET_CYCLES(2), .MAX_CYCLES(8), .CNT_W(CNT_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TOHOST_ADDR(3), .PASS_VALUE(1)
  ) dut (
    .CLK(CLK), .reset(reset), .start(start), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .core_en(core_en), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .exit_code(exit_code)
  );

  selevy_run_ctrl #(
    .RESET_CYCLES(1), .MAX_CYCLES(0), .CNT_W(CNT2_W), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .TOHOST_ADDR(3), .PASS_VALUE(1)
  ) dut_unl (
    .CLK(CLK), .reset(reset), .start(start2), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_reset(core_reset2), .core_en(core_en2), .busy(busy2), .done(done2),
    .pass(pass2), .timeout(timeout2), .cycle_count(cycle_count2),
    .exit_code(exit_code2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic              pass;
    logic              timeout;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] exitc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: a rising done is the DUT presenting a result.
  initial begin : monitor
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("res_pass", pass, e.pass);
          chk("res_timeout", timeout, e.timeout);
          chk("res_cycle_count", cycle_count, e.cnt);
          chk("res_exit_code", exit_code, e.exitc);
          chk("res_busy", busy, 1'b0);
          chk("res_core_en", core_en, 1'b0);
          chk("res_core_reset", core_reset, 1'b1);
        end
      end
      prev_done = done;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start a run and walk through the RESET phase; returns with the next
  // edge being the first RUN edge.
  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_clear", {done, pass, timeout}, 3'b000);
    chk("start_clear_cnt", cycle_count, 16'd0);
    chk("start_clear_exit", exit_code, 32'd0);
    chk("rst1_core", {core_reset, core_en}, 2'b10);
    tick();
    chk("rst2_core", {core_reset, core_en}, 2'b10);
    tick();
    chk("run_core", {core_reset, core_en}, 2'b01);
  endtask

  task automatic tohost_after(input int n, input logic [DATA_W-1:0] data);
    repeat (n) tick();
    chk("run_count_pre", cycle_count, n);
    chk("run_not_done", done, 1'b0);
    mem_we    = 1'b1;
    mem_waddr = 32'd3;
    mem_wdata = data;
    tick();
    mem_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done", done, 1'b1);
    tick();
    tick();
  endtask

  initial begin : stimulus
    // 1: reset values, then idle hold
    tick();
    tick();
    reset = 1'b0;
    chk("reset_ctrl", {core_reset, core_en, busy, done, pass, timeout}, 6'b100000);
    chk("reset_cnt", cycle_count, 16'd0);
    chk("reset_exit", exit_code, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hold", {core_reset, core_en, busy, done, pass, timeout}, 6'b100000);
    end

    // 2: pass on 4th RUN cycle
    launch();
    exp_q.push_back('{pass: 1'b1, timeout: 1'b0, cnt: 16'd4, exitc: 32'd1});
    tohost_after(3, 32'd1);
    chk("done_sticky", {done, pass, timeout}, 3'b110);

    // 3: fail value on 4th RUN cycle
    launch();
    exp_q.push_back('{pass: 1'b0, timeout: 1'b0, cnt: 16'd4, exitc: 32'd5});
    tohost_after(3, 32'd5);

    // 4: timeout; tohost writes outside RUN and other-address writes ignored
    mem_we    = 1'b1;
    mem_waddr = 32'd3;
    mem_wdata = 32'd1;
    launch();
    mem_waddr = 32'd2;
    exp_q.push_back('{pass: 1'b0, timeout: 1'b1, cnt: 16'd8, exitc: 32'd0});
    wait_done(20);
    mem_we = 1'b0;
    tick();
    chk("timeout_hold_cnt", cycle_count, 16'd8);
    chk("timeout_hold", {done, pass, timeout, busy}, 4'b1010);

    // 5: tohost on the final budget cycle beats timeout
    launch();
    exp_q.push_back('{pass: 1'b1, timeout: 1'b0, cnt: 16'd8, exitc: 32'd1});
    tohost_after(7, 32'd1);

    // 6: start ignored during RUN, then reset mid-run
    launch();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_ign_cnt", cycle_count, 16'd2);
    chk("run_start_ign", {busy, core_en, core_reset}, 3'b110);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrun_reset_ctrl", {core_reset, core_en, busy, done, pass, timeout}, 6'b100000);
    chk("midrun_reset_cnt", cycle_count, 16'd0);
    chk("midrun_reset_exit", exit_code, 32'd0);
    repeat (4) tick();
    chk("post_reset_idle", {core_reset, core_en, busy, done}, 4'b1000);

    // 7: unlimited budget, counter saturates, tohost still terminates
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("unl_reset_phase", {core_reset2, core_en2, busy2}, 3'b101);
    tick();
    chk("unl_run", {core_reset2, core_en2}, 2'b01);
    repeat (12) tick();
    chk("unl_saturate", cycle_count2, 3'd7);
    chk("unl_running", {busy2, done2, timeout2}, 3'b100);
    mem_we    = 1'b1;
    mem_waddr = 32'd3;
    mem_wdata = 32'd9;
    tick();
    mem_we = 1'b0;
    chk("unl_result", {done2, pass2, timeout2, busy2, core_en2}, 5'b10000);
    chk("unl_result_cnt", cycle_count2, 3'd7);
    chk("unl_result_exit", exit_code2, 32'd9);
    tick();
    chk("idle_ignores_tohost", done, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
